io_sw_responder: RTL and testbench
==================================

IO_SW_RESPONDER -- requirements
Module: io_sw_responder

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4, consecutive stable synchronized cycles before a switch change is accepted; legal range 2..255.
REQ-002 i_clk  input  1  single clock; all state updates on rising edge.
REQ-003 i_rst  input  1  reset, asynchronous, active-high.
REQ-004 i_io_sw  input  32  raw switch levels, asynchronous to i_clk.
REQ-005 i_lsu_addr  input  12  byte address inside IO window; bits [1:0] ignored.
REQ-006 i_lsu_rden  input  1  single-cycle read request from core LSU.
REQ-007 i_lsu_wren  input  1  single-cycle write request from core LSU.
REQ-008 i_lsu_wdata  input  32  write data.
REQ-009 o_lsu_rdata  output  32  registered read data, valid while o_lsu_ack high.
REQ-010 o_lsu_ack  output  1  one-cycle completion pulse for every request.
REQ-011 o_io_ledr  output  32  red LED register.
REQ-012 o_io_ledg  output  32  green LED register.

Function
REQ-013 Register map, word offsets: 0x000 SW_VAL (RO, debounced switches); 0x004 SW_CHG (sticky change bits, write-1-to-clear); 0x008 LEDR (RW); 0x00C LEDG (RW).
REQ-014 i_io_sw passes a 2-flop synchronizer per bit before any other use.
REQ-015 Debounce: one shared counter; it restarts when synchronized value differs from previous cycle's; when synchronized value has been unchanged for DEBOUNCE_CYCLES consecutive cycles, SW_VAL loads it.
REQ-016 Stable i_io_sw change becomes visible in SW_VAL exactly 2+DEBOUNCE_CYCLES rising edges after the change is sampled.
REQ-017 Glitch shorter than DEBOUNCE_CYCLES synchronized cycles does not change SW_VAL or SW_CHG.
REQ-018 On each SW_VAL update, SW_CHG |= old SW_VAL XOR new SW_VAL.
REQ-019 Write to SW_CHG clears bits where i_lsu_wdata is 1; same-cycle set and clear of one bit: set wins.
REQ-020 Write to LEDR/LEDG loads full 32-bit word; o_io_ledr/o_io_ledg drive register directly, updated on edge ending write cycle.
REQ-021 Writes to SW_VAL and unmapped offsets are ignored; reads of unmapped offsets return 0.
REQ-022 Request in cycle N gives o_lsu_ack=1 in cycle N+1 only; o_lsu_rdata holds read value in N+1 (0 for writes), 0 whenever ack low.
REQ-023 Back-to-back requests every cycle accepted; each acked one cycle later, no stalls.
REQ-024 i_lsu_rden and i_lsu_wren both high: write performed, single ack, o_lsu_rdata=0.
REQ-025 Read of LEDR/LEDG in cycle after a write to same register returns new value.
REQ-026 Read of SW_VAL/SW_CHG returns value registered at edge ending request cycle, including same-edge debounce update.

Reset
REQ-027 i_rst high immediately clears synchronizer, counter, SW_VAL, SW_CHG, LEDR, LEDG, o_lsu_rdata, o_lsu_ack to 0, independent of i_clk.
REQ-028 Request in flight when i_rst asserts is dropped, no ack after release; first request accepted on first rising edge with i_rst low.
REQ-029 After reset release with nonzero switches, SW_VAL reaches them per REQ-016 and SW_CHG records the 0->1 bits.

Configuration
REQ-030 Macro IO_SW_DEBOUNCE_EN defined: debounce counter per REQ-015..017 built.
REQ-031 Macro undefined: counter omitted, SW_VAL loads synchronizer output every cycle, latency 3 edges, DEBOUNCE_CYCLES ignored; SW_CHG still per REQ-018.

Verification
REQ-032 Reset, i_io_sw=0xA5A5A5A5 held -> with macro and DEBOUNCE_CYCLES=4, SW_VAL=0xA5A5A5A5 6 edges later, SW_CHG=0xA5A5A5A5; read 0x000 acks next cycle with that value.
REQ-033 Bit 0 pulsed high for 2 cycles, DEBOUNCE_CYCLES=4 -> SW_VAL and SW_CHG unchanged.
REQ-034 Write 0x004 data 0x0000FFFF with SW_CHG=0xA5A5A5A5 -> SW_CHG=0xA5A50000; same-cycle new change on bit 0 -> bit 0 stays 1.
REQ-035 Write 0x008=0x12345678, read 0x008 next cycle, write 0x00C=0xFF -> o_io_ledr=0x12345678, read returns 0x12345678, o_io_ledg=0x000000FF; three acks in consecutive cycles.
REQ-036 Read 0x010 -> ack, rdata 0; rden+wren to 0x008 data 0x1 -> LEDR=1, rdata 0.
REQ-037 i_rst pulsed mid-debounce with pending read -> all outputs 0 at once, no ack after release.

Source files
------------

// File: rtl/io_sw_responder.sv
// Switch/LED responder on the core LSU bus: synchronised and debounced switches, sticky change bits, two LED registers.
// Define IO_SW_DEBOUNCE_EN to build the shared debounce counter; without it SW_VAL follows the synchronizer directly.
module io_sw_responder #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_io_sw,
  input  logic [11:0] i_lsu_addr,
  input  logic        i_lsu_rden,
  input  logic        i_lsu_wren,
  input  logic [31:0] i_lsu_wdata,
  output logic [31:0] o_lsu_rdata,
  output logic        o_lsu_ack,
  output logic [31:0] o_io_ledr,
  output logic [31:0] o_io_ledg
);

  localparam logic [9:0] ADDR_SW_VAL = 10'd0;
  localparam logic [9:0] ADDR_SW_CHG = 10'd1;
  localparam logic [9:0] ADDR_LEDR   = 10'd2;
  localparam logic [9:0] ADDR_LEDG   = 10'd3;

  logic [31:0] r_sync1;
  logic [31:0] r_sync2;
  logic [31:0] r_swVal;
  logic [31:0] r_swChg;
  logic [31:0] r_ledr;
  logic [31:0] r_ledg;
  logic [31:0] r_rdata;
  logic        r_ack;

  logic [9:0]  w_wordAddr;
  logic        w_isWrite;
  logic        w_isRead;
  logic        w_load;
  logic [31:0] w_swValNext;
  logic [31:0] w_chgSet;
  logic [31:0] w_chgClr;
  logic [31:0] w_swChgNext;
  logic [31:0] w_readData;
  logic        w_unusedAddrLsbs;

  assign w_wordAddr       = i_lsu_addr[11:2];
  assign w_unusedAddrLsbs = ^i_lsu_addr[1:0];
  assign w_isWrite        = i_lsu_wren;
  assign w_isRead         = i_lsu_rden & ~i_lsu_wren;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= i_io_sw;
      r_sync2 <= r_sync1;
    end
  end

`ifdef IO_SW_DEBOUNCE_EN
  localparam logic [7:0] CNT_MAX = 8'(DEBOUNCE_CYCLES);

  logic [31:0] r_prev;
  logic [7:0]  r_cnt;
  logic [7:0]  w_stable;

  // w_stable counts the current cycle too, so a fresh change starts at 1 and saturates at CNT_MAX
  always_comb begin
    w_stable = 8'd1;
    if (r_sync2 == r_prev) begin
      w_stable = (r_cnt == CNT_MAX) ? CNT_MAX : (r_cnt + 8'd1);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_prev <= '0;
      r_cnt  <= '0;
    end else begin
      r_prev <= r_sync2;
      r_cnt  <= w_stable;
    end
  end

  assign w_load = (w_stable == CNT_MAX);
`else
  // DEBOUNCE_CYCLES is never 0, so this loads every cycle
  assign w_load = (DEBOUNCE_CYCLES != 0);
`endif

  assign w_swValNext = w_load ? r_sync2 : r_swVal;
  assign w_chgSet    = w_load ? (r_swVal ^ r_sync2) : '0;
  assign w_chgClr    = (w_isWrite && (w_wordAddr == ADDR_SW_CHG)) ? i_lsu_wdata : '0;
  assign w_swChgNext = (r_swChg & ~w_chgClr) | w_chgSet;

  // Switch registers are read at their next value so a same-edge update is visible
  always_comb begin
    w_readData = '0;
    if (w_isRead) begin
      case (w_wordAddr)
        ADDR_SW_VAL: w_readData = w_swValNext;
        ADDR_SW_CHG: w_readData = w_swChgNext;
        ADDR_LEDR:   w_readData = r_ledr;
        ADDR_LEDG:   w_readData = r_ledg;
        default:     w_readData = '0;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_swVal <= '0;
      r_swChg <= '0;
      r_ledr  <= '0;
      r_ledg  <= '0;
      r_rdata <= '0;
      r_ack   <= 1'b0;
    end else begin
      r_swVal <= w_swValNext;
      r_swChg <= w_swChgNext;
      if (w_isWrite && (w_wordAddr == ADDR_LEDR)) begin
        r_ledr <= i_lsu_wdata;
      end
      if (w_isWrite && (w_wordAddr == ADDR_LEDG)) begin
        r_ledg <= i_lsu_wdata;
      end
      r_rdata <= w_readData;
      r_ack   <= i_lsu_rden | i_lsu_wren;
    end
  end

  assign o_lsu_rdata = r_rdata;
  assign o_lsu_ack   = r_ack;
  assign o_io_ledr   = r_ledr;
  assign o_io_ledg   = r_ledg;

endmodule

// File: tb/tb_io_sw_responder.sv
// Bench for io_sw_responder: reset, directed bus vectors, switch latency/glitch/W1C sequences, then random traffic vs a window model.
// Expectations follow the IO_SW_DEBOUNCE_EN setting of the build.
module tb_io_sw_responder;

  localparam int DEB = 4;
`ifdef IO_SW_DEBOUNCE_EN
  localparam int WIN = DEB;
`else
  localparam int WIN = 1;
`endif
  localparam int LAT = WIN + 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ioSw;
  logic [11:0] lsuAddr;
  logic        lsuRden;
  logic        lsuWren;
  logic [31:0] lsuWdata;
  logic [31:0] lsuRdata;
  logic        lsuAck;
  logic [31:0] ioLedr;
  logic [31:0] ioLedg;

  int nChecks = 0;
  int nFails  = 0;

  io_sw_responder #(.DEBOUNCE_CYCLES(DEB)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_io_sw     (ioSw),
    .i_lsu_addr  (lsuAddr),
    .i_lsu_rden  (lsuRden),
    .i_lsu_wren  (lsuWren),
    .i_lsu_wdata (lsuWdata),
    .o_lsu_rdata (lsuRdata),
    .o_lsu_ack   (lsuAck),
    .o_io_ledr   (ioLedr),
    .o_io_ledg   (ioLedg)
  );

  always #5 clk = ~clk;

  // Reference model: SW_VAL takes the value sampled two edges ago once the last WIN samples agree
  logic [31:0] hist[$];
  logic [31:0] mSwVal, mSwChg, mLedr, mLedg, mRdata;
  logic        mAck;

  function automatic void modelReset();
    hist.delete();
    for (int i = 0; i < WIN + 2; i++) hist.push_back(32'h0);
    mSwVal = '0; mSwChg = '0; mLedr = '0; mLedg = '0; mRdata = '0; mAck = 1'b0;
  endfunction

  function automatic void modelEdge();
    int n;
    bit stable;
    logic [31:0] cand, setBits, clrBits;
    int word;
    hist.push_back(ioSw);
    n = hist.size();
    cand = hist[n-3];
    stable = 1'b1;
    for (int i = 0; i < WIN; i++) if (hist[n-3-i] != cand) stable = 1'b0;
    setBits = '0;
    if (stable) begin
      setBits = mSwVal ^ cand;
      mSwVal  = cand;
    end
    word = int'(lsuAddr) / 4;
    clrBits = (lsuWren && word == 1) ? lsuWdata : 32'h0;
    mSwChg = (mSwChg & ~clrBits) | setBits;
    mRdata = '0;
    if (lsuWren) begin
      if (word == 2) mLedr = lsuWdata;
      if (word == 3) mLedg = lsuWdata;
    end else if (lsuRden) begin
      case (word)
        0: mRdata = mSwVal;
        1: mRdata = mSwChg;
        2: mRdata = mLedr;
        3: mRdata = mLedg;
        default: mRdata = '0;
      endcase
    end
    mAck = lsuRden | lsuWren;
    while (hist.size() > WIN + 3) void'(hist.pop_front());
  endfunction

  task automatic applyStimulus(input logic rd, input logic wr, input logic [11:0] a, input logic [31:0] d);
    lsuRden = rd; lsuWren = wr; lsuAddr = a; lsuWdata = d;
  endtask

  task automatic stepCycle();
    @(posedge clk);
    if (!rst) modelEdge();
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic checkModel(input int cyc);
    checkOutput($sformatf("rndAck%0d", cyc), {31'b0, lsuAck}, {31'b0, mAck});
    checkOutput($sformatf("rndRdata%0d", cyc), lsuRdata, mRdata);
    checkOutput($sformatf("rndLedr%0d", cyc), ioLedr, mLedr);
    checkOutput($sformatf("rndLedg%0d", cyc), ioLedg, mLedg);
  endtask

  task automatic pulseReset();
    #1 rst = 1'b1;
    modelReset();
    #1 rst = 1'b0;
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic        expAck;
    logic [31:0] expRdata;
    logic [31:0] expLedr;
    logic [31:0] expLedg;
  } vec_t;

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{1'b0, 1'b1, 12'h008, 32'h12345678, 1'b1, 32'h0,        32'h12345678, 32'h0};
    vecs[1]  = '{1'b1, 1'b0, 12'h008, 32'h0,        1'b1, 32'h12345678, 32'h12345678, 32'h0};
    vecs[2]  = '{1'b0, 1'b1, 12'h00C, 32'h000000FF, 1'b1, 32'h0,        32'h12345678, 32'hFF};
    vecs[3]  = '{1'b0, 1'b0, 12'h000, 32'h0,        1'b0, 32'h0,        32'h12345678, 32'hFF};
    vecs[4]  = '{1'b1, 1'b0, 12'h010, 32'h0,        1'b1, 32'h0,        32'h12345678, 32'hFF};
    vecs[5]  = '{1'b1, 1'b1, 12'h008, 32'h1,        1'b1, 32'h0,        32'h1,        32'hFF};
    vecs[6]  = '{1'b1, 1'b0, 12'h00C, 32'h0,        1'b1, 32'hFF,       32'h1,        32'hFF};
    vecs[7]  = '{1'b0, 1'b1, 12'h000, 32'hFFFFFFFF, 1'b1, 32'h0,        32'h1,        32'hFF};
    vecs[8]  = '{1'b1, 1'b0, 12'h000, 32'h0,        1'b1, 32'h0,        32'h1,        32'hFF};
    vecs[9]  = '{1'b0, 1'b1, 12'h100, 32'h0000DEAD, 1'b1, 32'h0,        32'h1,        32'hFF};
    vecs[10] = '{1'b1, 1'b0, 12'h008, 32'h0,        1'b1, 32'h1,        32'h1,        32'hFF};
    vecs[11] = '{1'b1, 1'b0, 12'h00B, 32'h0,        1'b1, 32'h1,        32'h1,        32'hFF};

    rst = 1'b1;
    ioSw = '0;
    applyStimulus(1'b0, 1'b0, 12'h0, 32'h0);
    modelReset();
    #1;
    checkOutput("resetAck", {31'b0, lsuAck}, 32'h0);
    checkOutput("resetRdata", lsuRdata, 32'h0);
    checkOutput("resetLedr", ioLedr, 32'h0);
    checkOutput("resetLedg", ioLedg, 32'h0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;

    $display("[TB] directed bus vectors");
    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata);
      stepCycle();
      checkOutput($sformatf("vecAck%0d", i), {31'b0, lsuAck}, {31'b0, vecs[i].expAck});
      checkOutput($sformatf("vecRdata%0d", i), lsuRdata, vecs[i].expRdata);
      checkOutput($sformatf("vecLedr%0d", i), ioLedr, vecs[i].expLedr);
      checkOutput($sformatf("vecLedg%0d", i), ioLedg, vecs[i].expLedg);
    end

    $display("[TB] switch latency after reset");
    applyStimulus(1'b0, 1'b0, 12'h0, 32'h0);
    pulseReset();
    ioSw = 32'hA5A5A5A5;
    applyStimulus(1'b1, 1'b0, 12'h000, 32'h0);
    for (int k = 1; k <= 8; k++) begin
      stepCycle();
      checkOutput($sformatf("latAck%0d", k), {31'b0, lsuAck}, 32'h1);
      checkOutput($sformatf("latSwVal%0d", k), lsuRdata, (k >= LAT) ? 32'hA5A5A5A5 : 32'h0);
    end
    applyStimulus(1'b1, 1'b0, 12'h004, 32'h0);
    stepCycle();
    checkOutput("latSwChg", lsuRdata, 32'hA5A5A5A5);

    $display("[TB] write-1-to-clear and set priority");
    applyStimulus(1'b0, 1'b1, 12'h004, 32'h0000FFFF);
    stepCycle();
    applyStimulus(1'b1, 1'b0, 12'h004, 32'h0);
    stepCycle();
    checkOutput("w1cPartial", lsuRdata, 32'hA5A50000);
    applyStimulus(1'b0, 1'b0, 12'h0, 32'h0);
    ioSw = 32'hA5A5A5A4;
    repeat (LAT - 1) stepCycle();
    applyStimulus(1'b0, 1'b1, 12'h004, 32'h1);
    stepCycle();
    applyStimulus(1'b1, 1'b0, 12'h004, 32'h0);
    stepCycle();
    checkOutput("setWinsChg", lsuRdata, 32'hA5A50001);
    applyStimulus(1'b1, 1'b0, 12'h000, 32'h0);
    stepCycle();
    checkOutput("setWinsVal", lsuRdata, 32'hA5A5A5A4);

    $display("[TB] two-cycle glitch on bit 0");
    applyStimulus(1'b0, 1'b1, 12'h004, 32'hFFFFFFFF);
    stepCycle();
    applyStimulus(1'b0, 1'b0, 12'h0, 32'h0);
    ioSw = 32'hA5A5A5A5;
    repeat (2) stepCycle();
    ioSw = 32'hA5A5A5A4;
    repeat (10) stepCycle();
    applyStimulus(1'b1, 1'b0, 12'h000, 32'h0);
    stepCycle();
    checkOutput("glitchVal", lsuRdata, 32'hA5A5A5A4);
    applyStimulus(1'b1, 1'b0, 12'h004, 32'h0);
    stepCycle();
`ifdef IO_SW_DEBOUNCE_EN
    checkOutput("glitchChg", lsuRdata, 32'h0);
`else
    checkOutput("glitchChg", lsuRdata, 32'h1);
`endif

    $display("[TB] reset during debounce with a read in flight");
    applyStimulus(1'b0, 1'b0, 12'h0, 32'h0);
    ioSw = 32'h0F0F0F0F;
    repeat (2) stepCycle();
    applyStimulus(1'b1, 1'b0, 12'h000, 32'h0);
    stepCycle();
    checkOutput("pendingAck", {31'b0, lsuAck}, 32'h1);
    applyStimulus(1'b0, 1'b0, 12'h0, 32'h0);
    #1 rst = 1'b1;
    modelReset();
    #1;
    checkOutput("midRstAck", {31'b0, lsuAck}, 32'h0);
    checkOutput("midRstRdata", lsuRdata, 32'h0);
    checkOutput("midRstLedr", ioLedr, 32'h0);
    checkOutput("midRstLedg", ioLedg, 32'h0);
    #1 rst = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      stepCycle();
      checkOutput($sformatf("postRstAck%0d", k), {31'b0, lsuAck}, 32'h0);
    end
    applyStimulus(1'b1, 1'b0, 12'h000, 32'h0);
    for (int k = 3; k <= 8; k++) begin
      stepCycle();
      checkOutput($sformatf("postRstSwVal%0d", k), lsuRdata, (k >= LAT) ? 32'h0F0F0F0F : 32'h0);
    end
    applyStimulus(1'b1, 1'b0, 12'h004, 32'h0);
    stepCycle();
    checkOutput("postRstSwChg", lsuRdata, 32'h0F0F0F0F);

    $display("[TB] random traffic against the model");
    for (int c = 0; c < 600; c++) begin
      logic [11:0] a;
      logic rd, wr;
      case ($urandom_range(0, 15))
        0: ioSw = $urandom;
        1: ioSw = ioSw ^ (32'h1 << $urandom_range(0, 31));
        default: ;
      endcase
      case ($urandom_range(0, 5))
        0: a = 12'h000;
        1: a = 12'h004;
        2: a = 12'h008;
        3: a = 12'h00C;
        4: a = 12'h010;
        default: a = 12'($urandom);
      endcase
      case ($urandom_range(0, 7))
        4, 5: begin rd = 1'b1; wr = 1'b0; end
        6: begin rd = 1'b0; wr = 1'b1; end
        7: begin rd = 1'b1; wr = 1'b1; end
        default: begin rd = 1'b0; wr = 1'b0; end
      endcase
      applyStimulus(rd, wr, a, $urandom);
      stepCycle();
      checkModel(c);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
